surf6_fwu_pingpong: RTL
=======================

Name: surf6_fwu_pingpong

Overview:
- Sysclk-domain front end of the firmware-update path, directly upstream of the firmware-update marker.
- Accepts firmware words and "mark" commands from the command decoder and steers the words into two half-buffers (A = half 0, B = half 1) of the update buffer.
- Generates the per-half write and mark flags the marker consumes, and holds each marked half locked until the PS reports it complete.

Parameters:
ADDR_BITS, 11, log2 of words per half-buffer (2048 words per half).
DATA_WIDTH, 32, firmware word width.

Ports:
sysclk_i  in  1  system clock; all ports synchronous to it.
rst_n_i  in  1  asynchronous active-low reset.
fwu_dat_i  in  DATA_WIDTH  firmware word.
fwu_valid_i  in  1  word strobe; one word per cycle.
fwu_mark_i  in  1  one-cycle pulse: close the active half and hand it to the PS.
fw_pscomplete_i  in  2  per-half PS-complete status, already synchronized to sysclk_i.
err_clr_i  in  1  clears the sticky error flags.
buf_we_o  out  1  buffer write enable.
buf_addr_o  out  ADDR_BITS+1  {half, offset}.
buf_dat_o  out  DATA_WIDTH  buffer write data.
fw_wr_o  out  2  one-cycle pulse on the first write into a half; clears the PS-complete flag for that half downstream.
fw_mark_o  out  2  one-cycle per-half mark pulse.
fwu_ready_o  out  1  the active half can accept a word.
active_half_o  out  1  half currently being filled.
half_busy_o  out  2  half is marked and awaiting PS completion.
mark_len_o  out  ADDR_BITS+1  word count of the most recently marked half.
drop_err_o  out  1  sticky: a word was dropped.
mark_err_o  out  1  sticky: a mark was ignored.

Behaviour:
- Reset: outputs and state clear asynchronously; release is synchronous.
  - All outputs go to 0.
  - Both halves go to FREE, active = 0, offset = 0.
  - The pscomplete edge registers clear.
  - Reset mid-fill or mid-BUSY discards all progress. No pulses are emitted during or on exit from reset.
- Per-half state machine: FREE -> FILLING -> BUSY -> FREE.
  - FREE -> FILLING on the first accepted word. Emits fw_wr_o[h] in the same cycle as that word's buf_we_o.
  - FILLING -> BUSY on an accepted mark.
    - Emits fw_mark_o[h].
    - Latches mark_len_o = offset, including a same-cycle write.
    - active toggles and offset resets to 0.
  - BUSY -> FREE on a rising edge of fw_pscomplete_i[h] (registered previous value 0, current 1) while BUSY. A level that is already high when BUSY is entered, i.e. a stale completion, is ignored.
- Write path, registered, 1 cycle latency:
  - A word with fwu_valid_i=1 is accepted when the active half is FREE or FILLING and offset < 2^ADDR_BITS.
  - Accepted word: buf_we_o=1, buf_addr_o={active, offset}, buf_dat_o=data on the next cycle, then offset increments.
  - Offset saturates at 2^ADDR_BITS (it carries ADDR_BITS+1 bits); it does not wrap.
  - Words arriving when the active half is BUSY or full are dropped: no buf_we_o, drop_err_o set.
- fwu_ready_o is combinational from state: active half not BUSY and offset < 2^ADDR_BITS.
- Mark:
  - fw_mark_o is registered, asserted 1 cycle after fwu_mark_i, so it coincides with the buf_we_o of a same-cycle word.
  - A mark on a FILLING half is accepted.
  - A mark on a FREE (empty) or BUSY half is ignored: no pulse, mark_err_o set.
- Simultaneous valid and mark: the word lands in the current half first (it counts in mark_len_o), then that half is marked. The next word goes to the other half.
- Both halves BUSY: fwu_ready_o=0 and all words drop until a completion edge.
- Completion edge and first write into the same half can coincide only if that half is BUSY, in which case the word is dropped that cycle. The FREE transition takes effect the next cycle.
- Sticky errors clear on err_clr_i. If an error event and err_clr_i occur in the same cycle, the set wins.

Test Plan:
- Reset, 3 words 0xA0..0xA2, mark -> buf_we_o at addrs 0x000..0x002, fw_wr_o=01 with the first write only, fw_mark_o=01 one cycle after the mark, mark_len_o=3, active_half_o=1, half_busy_o=01.
- Continue: 2 words, mark -> addrs 0x800, 0x801, fw_wr_o=10, fw_mark_o=10, half_busy_o=11, fwu_ready_o=0; a further word is dropped and drop_err_o=1.
- fw_pscomplete_i[0] held high before the mark, then kept high -> half 0 stays BUSY; drive it 0 then 1 -> half_busy_o[0] clears and writes resume at addr 0x000 with a fresh fw_wr_o=01.
- 2048 words into half 0, one more word, mark -> last write at 0x7FF, word 2049 dropped, mark_len_o=2048.
- fwu_valid_i and fwu_mark_i in the same cycle on an empty FILLING-less half -> the word is written and the half is marked, mark_len_o=1; a mark on a FREE half -> no fw_mark_o, mark_err_o=1; err_clr_i clears it.
- rst_n_i asserted mid-fill (offset 5, half 1 BUSY) -> outputs 0 immediately; after release, the next word goes to addr 0x000.

Source files
------------

// File: rtl/surf6_fwu_pingpong.sv
// surf6_fwu_pingpong
// Sysclk-domain front end of the firmware-update path. Firmware words from the
// command decoder are steered into two half-buffers (half 0 = A, half 1 = B).
// Each half walks FREE -> FILLING -> BUSY -> FREE: the first accepted word opens
// it, a mark hands it to the PS, and a rising PS-complete edge releases it.
//
// Ports:
//   sysclk_i         system clock, every port is synchronous to it
//   rst_n_i          asynchronous active-low reset
//   fwu_dat_i        firmware word
//   fwu_valid_i      word strobe, one word per cycle
//   fwu_mark_i       one-cycle pulse: close the active half, hand it to the PS
//   fw_pscomplete_i  per-half PS-complete level, already in the sysclk domain
//   err_clr_i        clears the sticky error flags
//   buf_we_o         buffer write enable (registered)
//   buf_addr_o       buffer address {half, offset}
//   buf_dat_o        buffer write data
//   fw_wr_o          per-half pulse on the first write into a half
//   fw_mark_o        per-half mark pulse, aligned with a same-cycle word's write
//   fwu_ready_o      active half can accept a word
//   active_half_o    half currently being filled
//   half_busy_o      half is marked and awaiting PS completion
//   mark_len_o       word count of the most recently marked half
//   drop_err_o       sticky: a word was dropped
//   mark_err_o       sticky: a mark was ignored
module surf6_fwu_pingpong #(
  parameter int ADDR_BITS  = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  sysclk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] fwu_dat_i,
  input  logic                  fwu_valid_i,
  input  logic                  fwu_mark_i,
  input  logic [1:0]            fw_pscomplete_i,
  input  logic                  err_clr_i,
  output logic                  buf_we_o,
  output logic [ADDR_BITS:0]    buf_addr_o,
  output logic [DATA_WIDTH-1:0] buf_dat_o,
  output logic [1:0]            fw_wr_o,
  output logic [1:0]            fw_mark_o,
  output logic                  fwu_ready_o,
  output logic                  active_half_o,
  output logic [1:0]            half_busy_o,
  output logic [ADDR_BITS:0]    mark_len_o,
  output logic                  drop_err_o,
  output logic                  mark_err_o
);

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    FILLING = 2'd1,
    BUSY    = 2'd2
  } half_state_t;

  half_state_t state_q [2];
  half_state_t state_d [2];
  logic                  active_q, active_d;
  logic [ADDR_BITS:0]    offset_q, offset_d;
  logic [1:0]            ps_prev_q;

  logic                  we_d;
  logic [ADDR_BITS:0]    addr_d;
  logic [DATA_WIDTH-1:0] dat_d;
  logic [1:0]            fw_wr_d, fw_mark_d;
  logic [ADDR_BITS:0]    mark_len_d;
  logic                  drop_err_d, mark_err_d;

  half_state_t           cur_state;
  logic                  full, accept, drop, mark_ok;
  logic [ADDR_BITS:0]    count;
  logic [1:0]            ps_rise;

  // The offset saturates at exactly 2^ADDR_BITS, so its top bit alone means
  // the active half is full.
  assign cur_state = state_q[active_q];
  assign full      = offset_q[ADDR_BITS];
  assign accept    = fwu_valid_i && (cur_state != BUSY) && !full;
  assign drop      = fwu_valid_i && !accept;
  // A mark on an empty half is still good when a word lands in it the same
  // cycle; that word is written first and counted in the mark length.
  assign mark_ok   = fwu_mark_i &&
                     ((cur_state == FILLING) || ((cur_state == FREE) && accept));
  assign count     = offset_q + {{ADDR_BITS{1'b0}}, accept};
  // Only a fresh 0->1 edge releases a half; a level already high on entry to
  // BUSY is a stale completion of the previous hand-off.
  assign ps_rise   = fw_pscomplete_i & ~ps_prev_q;

  // Next-state and registered-output logic for both halves and the write path.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      state_d[h] = state_q[h];
      if ((state_q[h] == BUSY) && ps_rise[h]) state_d[h] = FREE;
    end
    active_d   = active_q;
    offset_d   = offset_q;
    we_d       = accept;
    addr_d     = buf_addr_o;
    dat_d      = buf_dat_o;
    fw_wr_d    = 2'b00;
    fw_mark_d  = 2'b00;
    mark_len_d = mark_len_o;

    if (accept) begin
      addr_d = {active_q, offset_q[ADDR_BITS-1:0]};
      dat_d  = fwu_dat_i;
      if (cur_state == FREE) begin
        fw_wr_d[active_q]  = 1'b1;
        state_d[active_q]  = FILLING;
      end
    end

    if (mark_ok) begin
      state_d[active_q]   = BUSY;
      fw_mark_d[active_q] = 1'b1;
      mark_len_d          = count;
      active_d            = ~active_q;
      offset_d            = '0;
    end else if (accept) begin
      offset_d = count;
    end

    // Set beats clear when both happen in the same cycle.
    if (drop)                       drop_err_d = 1'b1;
    else if (err_clr_i)             drop_err_d = 1'b0;
    else                            drop_err_d = drop_err_o;
    if (fwu_mark_i && !mark_ok)     mark_err_d = 1'b1;
    else if (err_clr_i)             mark_err_d = 1'b0;
    else                            mark_err_d = mark_err_o;
  end

  // State and output registers.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q[0] <= FREE;
      state_q[1] <= FREE;
      active_q   <= 1'b0;
      offset_q   <= '0;
      ps_prev_q  <= 2'b00;
      buf_we_o   <= 1'b0;
      buf_addr_o <= '0;
      buf_dat_o  <= '0;
      fw_wr_o    <= 2'b00;
      fw_mark_o  <= 2'b00;
      mark_len_o <= '0;
      drop_err_o <= 1'b0;
      mark_err_o <= 1'b0;
    end else begin
      state_q[0] <= state_d[0];
      state_q[1] <= state_d[1];
      active_q   <= active_d;
      offset_q   <= offset_d;
      ps_prev_q  <= fw_pscomplete_i;
      buf_we_o   <= we_d;
      buf_addr_o <= addr_d;
      buf_dat_o  <= dat_d;
      fw_wr_o    <= fw_wr_d;
      fw_mark_o  <= fw_mark_d;
      mark_len_o <= mark_len_d;
      drop_err_o <= drop_err_d;
      mark_err_o <= mark_err_d;
    end
  end

  assign active_half_o  = active_q;
  assign half_busy_o[0] = (state_q[0] == BUSY);
  assign half_busy_o[1] = (state_q[1] == BUSY);
  // Gated with reset so that every output, ready included, reads 0 while
  // reset is held even though the cleared state would otherwise mean ready.
  assign fwu_ready_o    = rst_n_i && (cur_state != BUSY) && !full;

endmodule
